// File: rtl/cmd_ram_ctrl_if.sv
// Command/response bundle between the SPI slave deserialiser/serialiser and the RAM controller.
// The master drives commands; the slave (the controller) returns read data and its busy flag.
interface cmd_ram_ctrl_if #(
  parameter int unsigned PAYLOAD_W  = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [PAYLOAD_W+1:0]  din;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  tx_valid;
  logic                  busy;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  busy
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output busy
  );
endinterface

// File: rtl/cmd_ram_ctrl.sv
// Command-driven single-port RAM with independent read/write pointers, optional auto-increment
// and a post-reset sweep that zeroes every word before commands are accepted.
module cmd_ram_ctrl #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAYLOAD_W  = 8,
  parameter bit          AUTO_INC   = 1'b1
) (
  input logic             clk,
  input logic             rst,
  cmd_ram_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    CmdWrAddr = 2'b00,
    CmdWrData = 2'b01,
    CmdRdAddr = 2'b10,
    CmdRdData = 2'b11
  } cmd_e;

  typedef enum logic {StClear, StIdle} state_e;

  localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] AddrOne  = ADDR_SIZE'(1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE-1:0]  clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  tx_valid_q, tx_valid_d;

  logic                  mem_we;
  logic [ADDR_SIZE-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  cmd_e                  cmd;
  logic [PAYLOAD_W-1:0]  payload;

  assign cmd     = cmd_e'(bus.din[PAYLOAD_W+1:PAYLOAD_W]);
  assign payload = bus.din[PAYLOAD_W-1:0];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    clr_ptr_d  = clr_ptr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = wr_ptr_q;
    mem_wdata  = '0;

    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_addr  = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + AddrOne;
        if (clr_ptr_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (bus.rx_valid) begin
          unique case (cmd)
            CmdWrAddr: wr_ptr_d = payload[ADDR_SIZE-1:0];
            CmdWrData: begin
              mem_we    = 1'b1;
              mem_wdata = payload[DATA_WIDTH-1:0];
              if (AUTO_INC) wr_ptr_d = wr_ptr_q + AddrOne;
            end
            CmdRdAddr: rd_ptr_d = payload[ADDR_SIZE-1:0];
            CmdRdData: begin
              // Array read sees the pre-edge contents, so a write accepted in the
              // following cycle cannot leak into this read.
              dout_d     = mem_q[rd_ptr_q];
              tx_valid_d = 1'b1;
              if (AUTO_INC) rd_ptr_d = rd_ptr_q + AddrOne;
            end
            default: ;
          endcase
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      clr_ptr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      clr_ptr_q  <= clr_ptr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // No reset on the array: the sweep is the only initialisation it gets.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = (state_q == StClear);

endmodule
